// File: rtl/morse_rx_decoder.sv
// Morse receiver: samples the lamp on half-second strobes and decodes letters A..H.
// Define MORSE_RX_ERRCNT_EN to build the saturating letter_err counter on err_count.
module morse_rx_decoder #(
   parameter int unsigned MAX_SYMS  = 4,
   parameter int unsigned MARK_MAX  = 3,
   parameter int unsigned GAP_TICKS = 3,
   parameter int unsigned CNT_W     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       half_sec,
   input  logic       light,
   output logic [2:0] letter_out,
   output logic       letter_valid,
   output logic       letter_err,
   output logic       busy,
   output logic [7:0] err_count
);

   localparam int unsigned SymCntW = $clog2(MAX_SYMS + 1);

   typedef enum logic [2:0] {StIdle, StMark, StSpace, StEmit, StError} state_e;

   state_e               state_q, state_d;
   logic [MAX_SYMS-1:0]  sym_q, sym_d;
   logic [SymCntW-1:0]   sym_cnt_q, sym_cnt_d;
   logic [CNT_W-1:0]     on_cnt_q, on_cnt_d;
   logic [CNT_W-1:0]     off_cnt_q, off_cnt_d;
   logic [2:0]           letter_q, letter_d;
   logic                 valid_q, valid_d;
   logic                 err_q, err_d;

   logic                 match;
   logic [2:0]           code;

   // Symbol store keeps the first symbol in bit 0 and unused upper bits at 0.
   always_comb begin
      match = 1'b1;
      code  = 3'd0;
      if (sym_cnt_q == SymCntW'(2) && sym_q == MAX_SYMS'(4'b0010)) begin
         code = 3'd0;
      end else if (sym_cnt_q == SymCntW'(4) && sym_q == MAX_SYMS'(4'b0001)) begin
         code = 3'd1;
      end else if (sym_cnt_q == SymCntW'(4) && sym_q == MAX_SYMS'(4'b0101)) begin
         code = 3'd2;
      end else if (sym_cnt_q == SymCntW'(3) && sym_q == MAX_SYMS'(4'b0001)) begin
         code = 3'd3;
      end else if (sym_cnt_q == SymCntW'(1) && sym_q == MAX_SYMS'(4'b0000)) begin
         code = 3'd4;
      end else if (sym_cnt_q == SymCntW'(4) && sym_q == MAX_SYMS'(4'b0100)) begin
         code = 3'd5;
      end else if (sym_cnt_q == SymCntW'(3) && sym_q == MAX_SYMS'(4'b0011)) begin
         code = 3'd6;
      end else if (sym_cnt_q == SymCntW'(4) && sym_q == MAX_SYMS'(4'b0000)) begin
         code = 3'd7;
      end else begin
         match = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      sym_d     = sym_q;
      sym_cnt_d = sym_cnt_q;
      on_cnt_d  = on_cnt_q;
      off_cnt_d = off_cnt_q;
      letter_d  = letter_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (half_sec && light) begin
               state_d  = StMark;
               on_cnt_d = CNT_W'(1);
            end
         end
         StMark: begin
            if (half_sec) begin
               if (light) begin
                  if (on_cnt_q <= CNT_W'(MARK_MAX)) on_cnt_d = on_cnt_q + CNT_W'(1);
               end else if (on_cnt_q > CNT_W'(MARK_MAX) ||
                            sym_cnt_q == SymCntW'(MAX_SYMS)) begin
                  state_d   = StError;
                  off_cnt_d = CNT_W'(1);
               end else begin
                  for (int i = 0; i < MAX_SYMS; i++) begin
                     if (sym_cnt_q == SymCntW'(i)) sym_d[i] = (on_cnt_q != CNT_W'(1));
                  end
                  sym_cnt_d = sym_cnt_q + SymCntW'(1);
                  off_cnt_d = CNT_W'(1);
                  state_d   = StSpace;
               end
            end
         end
         StSpace: begin
            if (half_sec) begin
               if (light) begin
                  state_d  = StMark;
                  on_cnt_d = CNT_W'(1);
               end else begin
                  off_cnt_d = off_cnt_q + CNT_W'(1);
                  // Decode now so the pulse lines up with the single EMIT cycle.
                  if (off_cnt_d >= CNT_W'(GAP_TICKS)) begin
                     state_d = StEmit;
                     valid_d = match;
                     err_d   = ~match;
                     if (match) letter_d = code;
                  end
               end
            end
         end
         StEmit: begin
            sym_d     = '0;
            sym_cnt_d = '0;
            on_cnt_d  = '0;
            off_cnt_d = '0;
            state_d   = StIdle;
         end
         StError: begin
            if (half_sec) begin
               if (light) begin
                  off_cnt_d = '0;
               end else begin
                  off_cnt_d = off_cnt_q + CNT_W'(1);
                  if (off_cnt_d >= CNT_W'(GAP_TICKS)) begin
                     err_d     = 1'b1;
                     sym_d     = '0;
                     sym_cnt_d = '0;
                     on_cnt_d  = '0;
                     off_cnt_d = '0;
                     state_d   = StIdle;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         sym_q     <= '0;
         sym_cnt_q <= '0;
         on_cnt_q  <= '0;
         off_cnt_q <= '0;
         letter_q  <= 3'd0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sym_q     <= sym_d;
         sym_cnt_q <= sym_cnt_d;
         on_cnt_q  <= on_cnt_d;
         off_cnt_q <= off_cnt_d;
         letter_q  <= letter_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   assign letter_out   = letter_q;
   assign letter_valid = valid_q;
   assign letter_err   = err_q;
   assign busy         = (state_q != StIdle);

`ifdef MORSE_RX_ERRCNT_EN
   logic [7:0] err_count_q, err_count_d;

   always_comb begin
      err_count_d = err_count_q;
      if (err_d && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) err_count_q <= 8'h00;
      else       err_count_q <= err_count_d;
   end

   assign err_count = err_count_q;
`else
   assign err_count = 8'h00;
`endif

endmodule
